divider: RTL and testbench
==========================

# divider

Multi-cycle integer divider for the CPU datapath, the inverse companion to the ALU multiplier. It accepts a 16-bit or 32-bit dividend (`ahigh:a`) and a 16-bit divisor (`b`), signed or unsigned. It runs a restoring shift-subtract loop that produces one quotient bit per cycle, and returns the quotient and remainder with ALU-style flags. The control unit stalls on `busy` and writes results back on `done`.

## Interface
- `N`, default 16: operand width; the dividend is up to 2N bits.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request a division; sampled only while idle.
- `signed_op` in 1: 1 = two's-complement operands, 0 = unsigned.
- `use32bit` in 1: 1 = dividend is `{ahigh,a}`; 0 = dividend is `a` extended to 2N bits (sign-extended if `signed_op`, zero-extended otherwise).
- `a` in N: dividend, low half.
- `ahigh` in N: dividend, high half.
- `b` in N: divisor.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse; results are valid from this cycle.
- `y` out N: quotient, low N bits.
- `yhigh` out N: remainder.
- `overflow` out 1: divide-by-zero, or quotient not representable in N bits.
- `zero` out 1: `y == 0`.
- `negative` out 1: `y[N-1]`.

## Operation
- Reset:
  - State returns to IDLE.
  - `busy`, `done`, `y`, `yhigh`, `overflow`, `zero`, `negative` all go to 0.
  - A reset mid-operation aborts the division; no `done` is produced.
- IDLE with `start=1`:
  - Latch the operands and mode bits.
  - Signed mode converts both operands to magnitudes and records the quotient sign (sign of dividend XOR sign of divisor) and the remainder sign (sign of dividend).
  - If `b==0`, go to FIX. Otherwise clear the 2N+1-bit partial remainder, clear the iteration counter, and go to DIV.
- DIV, 2N cycles:
  - Shift the next dividend bit (MSB first) into the partial remainder.
  - Trial-subtract the divisor magnitude.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - After iteration 2N-1, go to FIX.
- FIX, 1 cycle. Apply the signs:
  - The quotient truncates toward zero.
  - The remainder takes the dividend's sign.
  - Register the outputs and go to IDLE with `done=1`.
- Overflow:
  - Unsigned: set if quotient bits [2N-1:N] are nonzero.
  - Signed: set if the signed 2N-bit quotient falls outside [-2^(N-1), 2^(N-1)-1].
  - `y` always carries the low N bits of the signed-fixed quotient.
- Divide by zero: `y` = all ones, `yhigh` = `a`, `overflow` = 1.
- Start rules:
  - `start` while `busy` is ignored; the latched operands are unaffected.
  - `start` in the cycle where `done=1` is accepted, because the state is already IDLE.
- Output hold: `y`, `yhigh`, and the flags hold their values until the next `done`; they do not change during DIV.

## Timing
- Cycle 0: `start` is sampled high in IDLE.
- Normal division:
  - `busy=1` in cycles 1 through 2N+1 (DIV occupies cycles 1..2N, FIX is cycle 2N+1).
  - `done=1` and `busy=0` in cycle 2N+2, which is cycle 34 for N=16.
- Divide by zero: `busy=1` in cycle 1 (FIX), `done=1` in cycle 2.
- `done` is a single-cycle pulse; back-to-back operations need no idle gap.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `div_pkg` holds:
  - the state typedef (IDLE, DIV, FIX);
  - the default width constant `DIV_N = 16`;
  - the cycle-count constant `DIV_ITERS = 2*DIV_N`.
- No sub-module is required. Magnitude conversion and sign fix-up are local combinational logic inside `divider`.
- The iteration counter is log2(2N)+1 bits wide.

## Test plan
1. Unsigned 16-bit, a=100, b=7 → `done` in cycle 34; y=14, yhigh=2, overflow=0, zero=0.
2. Signed, a=0xFFF9 (-7), b=2 → y=0xFFFD (-3), yhigh=0xFFFF (-1), negative=1, overflow=0.
3. Unsigned 32-bit, ahigh=0x0001, a=0x0000, b=2 → y=0x8000, overflow=0. The same operands with `signed_op=1` → overflow=1, y=0x8000.
4. Divide by zero, a=0x1234, b=0 → `done` in cycle 2; y=0xFFFF, yhigh=0x1234, overflow=1.
5. Signed, a=0x8000, b=0xFFFF → y=0x8000, yhigh=0, overflow=1. Then `start` in the same cycle as `done` with a=9, b=3 → next `done` 34 cycles later, y=3, yhigh=0.
6. Pulse `start` again during cycle 5 with different operands → ignored; the original results appear. Then assert `reset` in cycle 10 of a new operation → `busy=0` next cycle, all outputs 0, no `done` pulse.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle divider.
package div_pkg;

  localparam int unsigned DIV_N     = 16;
  localparam int unsigned DIV_ITERS = 2 * DIV_N;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/divider.sv
// Restoring shift-subtract divider: 2N-bit dividend / N-bit divisor, one quotient bit
// per cycle, signed or unsigned, with registered quotient/remainder and ALU flags.
module divider
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         signed_op,
  input  logic         use32bit,
  input  logic [N-1:0] a,
  input  logic [N-1:0] ahigh,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] y,
  output logic [N-1:0] yhigh,
  output logic         overflow,
  output logic         zero,
  output logic         negative
);

  localparam int unsigned W2    = 2 * N;
  localparam int unsigned W1    = W2 + 1;
  localparam int unsigned ITERS = 2 * N;
  localparam int unsigned CNT_W = $clog2(ITERS) + 1;

  state_t           state_q, state_d;
  logic [W2-1:0]    dvd_q;
  logic [N-1:0]     dvs_q;
  logic [W1-1:0]    rem_q;
  logic [W2-1:0]    quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             q_neg_q, r_neg_q, signed_q, div0_q;
  logic [N-1:0]     a_q;

  logic [W2-1:0]    dvd_ext, dvd_mag;
  logic [N-1:0]     dvs_mag;
  logic             dvd_neg, dvs_neg;
  logic [W1-1:0]    trial, diff;
  logic             q_bit;
  logic [W2-1:0]    q_fix;
  logic [N:0]       q_top;
  logic [N-1:0]     y_fix, r_fix;
  logic             ovf_fix;

  // Operand magnitudes and signs, taken straight from the inputs at start.
  always_comb begin
    dvd_ext = '0;
    if (use32bit)       dvd_ext = {ahigh, a};
    else if (signed_op) dvd_ext = {{N{a[N-1]}}, a};
    else                dvd_ext = {{N{1'b0}}, a};
    dvd_neg = signed_op & dvd_ext[W2-1];
    dvs_neg = signed_op & b[N-1];
    dvd_mag = dvd_neg ? W2'(-dvd_ext) : dvd_ext;
    dvs_mag = dvs_neg ? N'(-b) : b;
  end

  // One restoring step: shift in next dividend bit, trial-subtract the divisor.
  always_comb begin
    trial = W1'({rem_q, dvd_q[W2-1]});
    diff  = trial - W1'(dvs_q);
    q_bit = ~diff[W1-1];
  end

  // Sign fix-up and flag generation for the FIX cycle.
  always_comb begin
    q_fix   = q_neg_q ? W2'(-quo_q) : quo_q;
    q_top   = q_fix[W2-1:N-1];
    ovf_fix = div0_q | (signed_q ? ~((&q_top) | ~(|q_top)) : (|quo_q[W2-1:N]));
    y_fix   = div0_q ? '1 : q_fix[N-1:0];
    r_fix   = rem_q[N-1:0];
    if (div0_q)       r_fix = a_q;
    else if (r_neg_q) r_fix = N'(-rem_q[N-1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (b == '0) ? FIX : DIV;
      DIV:     if (cnt_q == CNT_W'(ITERS - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      y        <= '0;
      yhigh    <= '0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      signed_q <= 1'b0;
      div0_q   <= 1'b0;
      a_q      <= '0;
    end else begin
      busy <= (state_d != IDLE);
      done <= (state_q == FIX);
      case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q    <= dvd_mag;
            dvs_q    <= dvs_mag;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            q_neg_q  <= dvd_neg ^ dvs_neg;
            r_neg_q  <= dvd_neg;
            signed_q <= signed_op;
            div0_q   <= (b == '0);
            a_q      <= a;
          end
        end
        DIV: begin
          rem_q <= q_bit ? diff : trial;
          quo_q <= {quo_q[W2-2:0], q_bit};
          dvd_q <= dvd_q << 1;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        FIX: begin
          y        <= y_fix;
          yhigh    <= r_fix;
          overflow <= ovf_fix;
          zero     <= (y_fix == '0);
          negative <= y_fix[N-1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: arithmetic reference model, latency and flag checks.
module tb_divider;
  import div_pkg::*;

  localparam int unsigned N = DIV_N;

  logic         clk = 1'b0;
  logic         reset, start, signed_op, use32bit;
  logic [N-1:0] a, ahigh, b;
  logic         busy, done, overflow, zero, negative;
  logic [N-1:0] y, yhigh;

  always #5 clk = ~clk;

  divider #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_op(signed_op),
    .use32bit(use32bit), .a(a), .ahigh(ahigh), .b(b),
    .busy(busy), .done(done), .y(y), .yhigh(yhigh),
    .overflow(overflow), .zero(zero), .negative(negative)
  );

  typedef struct {
    logic [N-1:0] y;
    logic [N-1:0] yh;
    logic         ovf;
    int           lat;
    int           s;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: native 64-bit division truncates toward zero; % takes dividend sign.
  function automatic exp_t model(input logic sop, input logic u32, input logic [N-1:0] av,
                                 input logic [N-1:0] ahv, input logic [N-1:0] bv, input int s);
    exp_t   e;
    longint dv, ds, q, r, lim;
    if (u32) dv = sop ? longint'($signed({ahv, av})) : longint'({ahv, av});
    else     dv = sop ? longint'($signed(av)) : longint'(av);
    e.s = s;
    if (bv == '0) begin
      e.y = '1; e.yh = av; e.ovf = 1'b1; e.lat = 2;
    end else begin
      ds  = sop ? longint'($signed(bv)) : longint'(bv);
      q   = dv / ds;
      r   = dv % ds;
      lim = longint'(1) << (N - 1);
      e.y   = q[N-1:0];
      e.yh  = r[N-1:0];
      e.ovf = sop ? ((q < -lim) || (q > lim - 1)) : (q >= (longint'(1) << N));
      e.lat = int'(2 * N + 2);
    end
    return e;
  endfunction

  // Result monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (!reset && done) begin
      check("done_pulse", 32'(prev_done), 32'(0));
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'(0));
      end else begin
        mon_e = sb.pop_front();
        check("y", 32'(y), 32'(mon_e.y));
        check("yhigh", 32'(yhigh), 32'(mon_e.yh));
        check("overflow", 32'(overflow), 32'(mon_e.ovf));
        check("zero", 32'(zero), 32'(mon_e.y == '0));
        check("negative", 32'(negative), 32'(mon_e.y[N-1]));
        check("latency", 32'(cyc - mon_e.s), 32'(mon_e.lat));
        check("busy_at_done", 32'(busy), 32'(0));
      end
    end
    prev_done <= done;
  end

  // Called at a negedge; leaves start high for one edge, then scrambles the inputs.
  task automatic issue(input logic sop, input logic u32, input logic [N-1:0] av,
                       input logic [N-1:0] ahv, input logic [N-1:0] bv, input bit expect_res);
    signed_op = sop; use32bit = u32; a = av; ahigh = ahv; b = bv; start = 1'b1;
    if (expect_res) sb.push_back(model(sop, u32, av, ahv, bv, cyc));
    @(negedge clk);
    start = 1'b0;
    a = N'($urandom); ahigh = N'($urandom); b = N'($urandom);
    signed_op = 1'($urandom); use32bit = 1'($urandom);
    check("busy_after_start", 32'(busy), 32'(1));
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!done) check("done_timeout", 32'(done), 32'(1));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; signed_op = 1'b0; use32bit = 1'b0;
    a = '0; ahigh = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_y", 32'(y), 32'(0));
    check("rst_flags", 32'({overflow, zero, negative}), 32'(0));
    reset = 1'b0;
    @(negedge clk);

    issue(1'b0, 1'b0, 16'd100, 16'd0, 16'd7, 1'b1);
    wait_done();
    check("t1_y", 32'(y), 32'd14);
    check("t1_yhigh", 32'(yhigh), 32'd2);

    issue(1'b1, 1'b0, 16'hFFF9, 16'd0, 16'd2, 1'b1);
    wait_done();
    check("t2_y", 32'(y), 32'h0000FFFD);
    check("t2_yhigh", 32'(yhigh), 32'h0000FFFF);

    issue(1'b0, 1'b1, 16'h0000, 16'h0001, 16'd2, 1'b1);
    wait_done();
    check("t3u_y", 32'(y), 32'h8000);
    issue(1'b1, 1'b1, 16'h0000, 16'h0001, 16'd2, 1'b1);
    wait_done();
    check("t3s_ovf", 32'(overflow), 32'd1);

    issue(1'b0, 1'b0, 16'h1234, 16'd0, 16'd0, 1'b1);
    wait_done();
    check("t4_yhigh", 32'(yhigh), 32'h1234);

    issue(1'b1, 1'b0, 16'h8000, 16'd0, 16'hFFFF, 1'b1);
    wait_done();
    issue(1'b0, 1'b0, 16'd9, 16'd0, 16'd3, 1'b1);
    wait_done();
    check("t5_y", 32'(y), 32'd3);

    // Start during DIV is ignored; outputs hold the previous result meanwhile.
    issue(1'b0, 1'b0, 16'd1000, 16'd0, 16'd33, 1'b1);
    repeat (4) @(negedge clk);
    check("hold_y", 32'(y), 32'd3);
    start = 1'b1; a = 16'd5; b = 16'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    @(negedge clk);
    issue(1'b0, 1'b0, 16'd500, 16'd0, 16'd7, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_outs", 32'({y, yhigh}), 32'(0));
    check("abort_flags", 32'({done, overflow, zero, negative}), 32'(0));
    reset = 1'b0;
    repeat (40) @(negedge clk);

    issue(1'b0, 1'b0, 16'd0, 16'd0, 16'd5, 1'b1);
    wait_done();
    issue(1'b1, 1'b0, 16'h8000, 16'd0, 16'd1, 1'b1);
    wait_done();
    issue(1'b1, 1'b1, 16'h0000, 16'h8000, 16'hFFFF, 1'b1);
    wait_done();
    issue(1'b0, 1'b1, 16'hFFFF, 16'hFFFE, 16'hFFFF, 1'b1);
    wait_done();

    for (int i = 0; i < 24; i++) begin
      logic [N-1:0] rb;
      rb = ($urandom_range(0, 7) == 0) ? N'(0) : N'($urandom_range(1, 300));
      if (i % 2 == 0) rb = N'($urandom);
      issue(1'($urandom), 1'($urandom), N'($urandom), N'($urandom_range(0, 600)), rb, 1'b1);
      wait_done();
    end

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
